// File: rtl/seg7_pkg.sv
// Shared types and constants for the step-counter display back-end.
// Holds the conversion FSM states and the active-low segment encodings.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    localparam logic [13:0] MAX_VAL   = 14'd9999;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;

    // Segment order is {g,f,e,d,c,b,a}, active low
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_bin2bcd.sv
// Iterative double-dabble engine: one IDLE sample, BIN_W shifts, one UPDATE.
// Exposes the pending result so the display can switch on the same edge.
module bin2bcd_iter
    import seg7_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin,
    output logic [15:0]      bcd,
    output logic             ovf,
    output logic             done,
    output logic [15:0]      res_bcd,
    output logic             res_ovf,
    output logic             upd
);

    state_t state, state_nx;
    logic [15+BIN_W:0] work, work_adj;
    logic [4:0] cnt;
    logic smp_ovf;

    always_comb begin
        state_nx = state;
        work_adj = work;
        for (int i = 0; i < 4; i++) begin
            if (work[BIN_W+4*i +: 4] >= 4'd5)
                work_adj[BIN_W+4*i +: 4] = work[BIN_W+4*i +: 4] + 4'd3;
        end
        case (state)
            IDLE:    state_nx = SHIFT;
            SHIFT:   if (cnt == 5'(BIN_W-1)) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign res_bcd = work[15+BIN_W -: 16];
    assign res_ovf = smp_ovf;
    assign upd     = (state == UPDATE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            work    <= '0;
            cnt     <= '0;
            smp_ovf <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == UPDATE);
            case (state)
                IDLE: begin
                    work    <= {16'd0, bin};
                    cnt     <= '0;
                    smp_ovf <= 32'(bin) > 32'(MAX_VAL);
                end
                // Top carry is dropped: thousands wrap, giving bin mod 10000
                SHIFT: begin
                    work <= {work_adj[14+BIN_W:0], 1'b0};
                    cnt  <= cnt + 5'd1;
                end
                UPDATE: begin
                    bcd <= work[15+BIN_W -: 16];
                    ovf <= smp_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Step-counter display: BCD conversion plus 4-digit common-anode scan.
// Digit drive is registered and follows the next-cycle bcd/ovf/index.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BIN_W    = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin,
    input  logic             blank_lz,
    output logic [15:0]      bcd,
    output logic             ovf,
    output logic             done,
    output logic [3:0]       an_n,
    output logic [6:0]       seg_n
);

    logic [15:0] pre;
    logic [1:0]  idx, idx_nx;
    logic        wrap;
    logic [15:0] res_bcd, bcd_nx;
    logic        res_ovf, ovf_nx, upd;
    logic [3:0]  nib, zero_hi;
    logic [6:0]  seg_nx;

    bin2bcd_iter #(.BIN_W(BIN_W)) u_conv (
        .clk     (clk),
        .reset   (reset),
        .bin     (bin),
        .bcd     (bcd),
        .ovf     (ovf),
        .done    (done),
        .res_bcd (res_bcd),
        .res_ovf (res_ovf),
        .upd     (upd)
    );

    always_comb begin
        wrap       = (pre == 16'(SCAN_DIV-1));
        idx_nx     = wrap ? idx + 2'd1 : idx;
        bcd_nx     = upd ? res_bcd : bcd;
        ovf_nx     = upd ? res_ovf : ovf;
        nib        = bcd_nx[4*idx_nx +: 4];
        zero_hi[3] = (bcd_nx[15:12] == 4'd0);
        zero_hi[2] = zero_hi[3] && (bcd_nx[11:8] == 4'd0);
        zero_hi[1] = zero_hi[2] && (bcd_nx[7:4] == 4'd0);
        zero_hi[0] = 1'b0;
        if (ovf_nx)
            seg_nx = SEG_DASH;
        else if (blank_lz && zero_hi[idx_nx])
            seg_nx = SEG_BLANK;
        else
            seg_nx = seg_of(nib);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre   <= '0;
            idx   <= '0;
            an_n  <= 4'b1110;
            seg_n <= 7'b1000000;
        end else begin
            pre   <= wrap ? 16'd0 : pre + 16'd1;
            idx   <= idx_nx;
            an_n  <= ~(4'b0001 << idx_nx);
            seg_n <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_DIV=4.
// Expected digits and segment patterns are hand-computed constants.
module tb_seg7_scan;

    logic        clk;
    logic        reset;
    logic [13:0] bin;
    logic        blank_lz;
    logic [15:0] bcd;
    logic        ovf;
    logic        done;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;

    int n_chk;
    int n_err;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    seg7_scan #(.SCAN_DIV(4), .BIN_W(14)) dut (
        .clk      (clk),
        .reset    (reset),
        .bin      (bin),
        .blank_lz (blank_lz),
        .bcd      (bcd),
        .ovf      (ovf),
        .done     (done),
        .an_n     (an_n),
        .seg_n    (seg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply(input logic [13:0] v, input logic blz);
        int c;
        @(negedge clk);
        bin = v;
        blank_lz = blz;
        wait_done(c);
        wait_done(c);
    endtask

    task automatic show_check(input string tag, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2,
                              input logic [6:0] e3);
        logic [6:0] seen [4];
        logic [6:0] exp [4];
        int hold [4];
        int bad;
        int d;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int k = 0; k < 4; k++) begin
            hold[k] = 0;
            seen[k] = 'x;
        end
        bad = 0;
        repeat (16) begin
            @(negedge clk);
            case (an_n)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            if (d < 0) bad++;
            else begin
                hold[d]++;
                seen[d] = seg_n;
            end
        end
        check({tag, "_an"}, 32'(bad), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_seg%0d", tag, k), 32'(seen[k]), 32'(exp[k]));
            check($sformatf("%s_hold%0d", tag, k), 32'(hold[k]), 32'd4);
        end
    endtask

    initial begin
        int c;
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        bin = 14'd0;
        blank_lz = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_an", 32'(an_n), 32'b1110);
        check("rst_seg", 32'(seg_n), 32'(S0));

        reset = 1'b0;
        wait_done(c);
        check("lat0", 32'(c), 32'd16);
        check("bcd0", 32'(bcd), 32'h0000);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        show_check("zero", S0, SB, SB, SB);

        apply(14'd9999, 1'b0);
        check("bcd9999", 32'(bcd), 32'h9999);
        check("ovf9999", 32'(ovf), 32'd0);
        show_check("n9999", S9, S9, S9, S9);

        apply(14'd1000, 1'b1);
        check("bcd1000", 32'(bcd), 32'h1000);
        show_check("n1000", S0, S0, S0, S1);

        apply(14'd40, 1'b1);
        check("bcd40", 32'(bcd), 32'h0040);
        show_check("n40", S0, S4, SB, SB);

        apply(14'd12000, 1'b1);
        check("ovf12000", 32'(ovf), 32'd1);
        check("bcd12000", 32'(bcd), 32'h2000);
        show_check("dash", SD, SD, SD, SD);

        wait_done(c);
        bin = 14'd1234;
        repeat (3) @(negedge clk);
        bin = 14'd5678;
        wait_done(c);
        check("hold1234", 32'(bcd), 32'h1234);
        check("ovf1234", 32'(ovf), 32'd0);
        wait_done(c);
        check("next5678", 32'(bcd), 32'h5678);

        bin = 14'd777;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_bcd", 32'(bcd), 32'h0);
        check("mid_ovf", 32'(ovf), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_an", 32'(an_n), 32'b1110);
        check("mid_seg", 32'(seg_n), 32'(S0));
        @(negedge clk);
        reset = 1'b0;
        wait_done(c);
        check("lat777", 32'(c), 32'd16);
        check("bcd777", 32'(bcd), 32'h0777);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
